// File: rtl/grid_pixel_streamer.sv
// grid_pixel_streamer: streams the GRID_SIZE x GRID_SIZE one-bit canvas as valid/ready activation samples.
// Define GRID_PIXEL_COUNT_EN to add the set_count output.
module grid_pixel_streamer #(
    parameter int GRID_SIZE = 28,
    parameter int DATA_W = 8,
    parameter logic [DATA_W-1:0] ON_VALUE = 8'd255,
    parameter logic [DATA_W-1:0] OFF_VALUE = 8'd0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [9:0]        mem_addr,
    output logic              mem_rd,
    input  logic              mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [9:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef GRID_PIXEL_COUNT_EN
    ,
    output logic [9:0]        set_count
`endif
);
    localparam logic [9:0] LAST_IDX = 10'(GRID_SIZE * GRID_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nx;

    logic [9:0] rd_cnt, idx_q;
    logic       rd_q, last_q;
    logic [1:0] cnt;
    logic       wp, rp;
    logic [1:0] fd, fl;
    logic [9:0] fi [2];
    logic       head_bit, head_last, fire, push, pop;
    logic [9:0] head_idx;

    // With the buffer empty, the read returning this cycle is presented directly.
    assign head_bit  = cnt != 2'd0 ? fd[rp] : mem_data;
    assign head_idx  = cnt != 2'd0 ? fi[rp] : idx_q;
    assign head_last = cnt != 2'd0 ? fl[rp] : last_q;
    assign out_valid = cnt != 2'd0 || rd_q;
    assign fire      = out_valid && out_ready;
    assign pop       = fire && cnt != 2'd0;
    assign push      = rd_q && !(fire && cnt == 2'd0);
    assign mem_rd    = state == STREAM && (cnt + {1'b0, rd_q}) < 2'd2;
    assign mem_addr  = rd_cnt;
    assign out_data  = out_valid && head_bit ? ON_VALUE : OFF_VALUE;
    assign out_index = head_idx;
    assign out_last  = out_valid && head_last;
    assign busy      = state != IDLE;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && start)
            state_nx = STREAM;
        else if (state == STREAM && mem_rd && rd_cnt == LAST_IDX)
            state_nx = DRAIN;
        else if (state == DRAIN && fire && out_last)
            state_nx = IDLE;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_cnt <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            rd_q   <= 1'b0;
            cnt    <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= state == DRAIN && fire && out_last;
            rd_q <= mem_rd;
            if (state == IDLE && start) begin
                rd_cnt <= '0;
            end else if (mem_rd) begin
                idx_q  <= rd_cnt;
                last_q <= rd_cnt == LAST_IDX;
                if (rd_cnt != LAST_IDX)
                    rd_cnt <= rd_cnt + 10'd1;
            end
            if (push) begin
                fd[wp] <= mem_data;
                fi[wp] <= idx_q;
                fl[wp] <= last_q;
                wp     <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef GRID_PIXEL_COUNT_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            set_count <= '0;
        else if (state == IDLE && start)
            set_count <= '0;
        else if (fire && head_bit)
            set_count <= set_count + 10'd1;
    end
`endif
endmodule

// File: tb/tb_grid_pixel_streamer.sv
// tb_grid_pixel_streamer: directed frames against a registered pixel-memory model.
module tb_grid_pixel_streamer;
    logic       CLOCK_50 = 1'b0;
    logic       reset, start, out_ready;
    logic [9:0] mem_addr, out_index;
    logic       mem_rd, out_valid, out_last, busy, done;
    logic       mem_data = 1'b0;
    logic [7:0] out_data;
    logic       canvas [784];
    int         total = 0;
    int         bad = 0;
`ifdef GRID_PIXEL_COUNT_EN
    logic [9:0] set_count;
`endif

    grid_pixel_streamer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
`ifdef GRID_PIXEL_COUNT_EN
        , .set_count(set_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50)
        if (mem_rd)
            mem_data <= canvas[int'(mem_addr)];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // poke: 0 none, 1 re-pulse start at index 400, 2 reset at index 500
    task automatic run_frame(input int mode, input int poke);
        int rel, exp_idx, dones, done_rel, last_rel, issued, xfers, occ, occ_max;
        logic pv, pr, fire, pl;
        logic [7:0] pd;
        logic [9:0] pi;
        rel = 0; exp_idx = 0; dones = 0; done_rel = -1; last_rel = -1;
        issued = 0; xfers = 0; occ_max = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        @(negedge CLOCK_50);
        start = 1'b1;
        out_ready = mode != 2;
        while (rel < 4000 && (done_rel < 0 || rel < done_rel + 5)) begin
            @(negedge CLOCK_50);
            rel++;
            start = 1'b0;
            if (mode == 0 && poke == 0 && rel == 1) begin
                check("rd_t1", mem_rd, 1);
                check("vld_t1", out_valid, 0);
            end
            if (mode == 0 && poke == 0 && rel == 2)
                check("vld_t2", out_valid, 1);
            if (pv && !pr)
                check("hold", {out_valid, out_data, out_index, out_last}, {1'b1, pd, pi, pl});
            if (mem_rd)
                issued++;
            occ = issued - xfers;
            if (occ > occ_max)
                occ_max = occ;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(1, 0)) : rel > 100;
            if (mode == 2 && rel == 100) begin
                check("stl_vld", out_valid, 1);
                check("stl_idx", out_index, 0);
                check("stl_rds", issued, 2);
            end
            fire = out_valid && out_ready;
            if (fire) begin
                check("idx", out_index, exp_idx);
                check("dat", out_data, canvas[exp_idx] ? 255 : 0);
                check("last", out_last, exp_idx == 783);
                if (out_last)
                    last_rel = rel;
                exp_idx++;
                xfers++;
            end
            if (done) begin
                dones++;
                done_rel = rel;
            end
            if (poke == 1 && fire && out_index == 10'd400)
                start = 1'b1;
            if (poke == 2 && fire && out_index == 10'd500) begin
                reset = 1'b1;
                @(negedge CLOCK_50);
                check("rst_vld", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                reset = 1'b0;
                repeat (5) begin
                    @(negedge CLOCK_50);
                    if (done)
                        dones++;
                end
                check("rst_nodone", dones, 0);
                return;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
        end
        check("xfers", exp_idx, 784);
        check("dones", dones, 1);
        check("occ", occ_max <= 2, 1);
        check("idle", busy, 0);
        if (mode == 0 && poke == 0) begin
            check("last_t", last_rel, 785);
            check("done_t", done_rel, 786);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 784; i++) canvas[i] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("r_vld", out_valid, 0);
        check("r_rd", mem_rd, 0);
        check("r_addr", mem_addr, 0);
        check("r_dat", out_data, 0);
        check("r_idx", out_index, 0);
        check("r_last", out_last, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        reset = 1'b0;
        run_frame(0, 0);
        canvas[0] = 1'b1; canvas[29] = 1'b1; canvas[783] = 1'b1;
        run_frame(0, 0);
`ifdef GRID_PIXEL_COUNT_EN
        check("set_cnt", set_count, 3);
`endif
        for (int i = 0; i < 784; i++) canvas[i] = 1'(((i / 28) + (i % 28)) % 2);
        run_frame(1, 0);
        for (int i = 0; i < 784; i++) canvas[i] = i % 3 == 0;
        run_frame(2, 0);
        for (int i = 0; i < 784; i++) canvas[i] = i % 7 == 2;
        run_frame(0, 1);
        run_frame(0, 2);
        run_frame(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
